lcd_ram_byte_reader: RTL and testbench

- Read-side sequencer for the 64x1 distributed LCD character RAM (asynchronous read, positive-edge write).
- Walks the RAM address bus, deserialises 8 consecutive bits into one character byte, and hands each byte to the LCD command/data writer over a valid/ready handshake.
- Sits between the 64x1 RAM instance and the LCD write FSM. One START pulse reads out a full frame of NUM_BYTES bytes.

---
 rtl/lcd_ram_pkg.sv | 19 +
 rtl/lcd_ram_byte_reader_if.sv | 27 ++
 rtl/lcd_bit_deserializer.sv | 46 ++++
 rtl/lcd_ram_byte_reader.sv | 108 ++++++++++
 tb/tb_lcd_ram_byte_reader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_ram_pkg.sv
// Shared widths, FSM encoding and address helper for the LCD character RAM reader.
package lcd_ram_pkg;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RAM_DEPTH = 64;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRead    = 2'd1,
        StPresent = 2'd2
    } state_e;

    // Bit address of the first bit of a character byte, wrapped into the RAM.
    function automatic logic [ADDR_W-1:0] byte_base_addr(input int unsigned byte_idx);
        return ADDR_W'((byte_idx * BYTE_W) % RAM_DEPTH);
    endfunction

endpackage

// File: rtl/lcd_ram_byte_reader_if.sv
// RAM read port plus byte valid/ready stream; master is the reader, slave is RAM + consumer.
interface lcd_ram_byte_reader_if;
    import lcd_ram_pkg::*;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rdata;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (
        output ram_addr,
        output byte_data,
        output byte_valid,
        input  ram_rdata,
        input  byte_ready
    );

    modport slave (
        input  ram_addr,
        input  byte_data,
        input  byte_valid,
        output ram_rdata,
        output byte_ready
    );

endinterface

// File: rtl/lcd_bit_deserializer.sv
// Collects eight serial RAM bits into one byte, LSB-first or MSB-first.
module lcd_bit_deserializer
    import lcd_ram_pkg::*;
#(
    parameter bit MsbFirst = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              sample_en_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              full_o
);

    logic [2:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [2:0]        idx;

    always_comb begin
        idx    = MsbFirst ? (3'd7 - cnt_q) : cnt_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (sample_en_i) begin
            data_d[idx] = bit_i;
            cnt_d       = cnt_q + 3'd1;
        end
    end

    // High on the sample that completes the byte; the counter wraps to 0 by itself.
    assign full_o = sample_en_i && (cnt_q == 3'd7);
    assign data_o = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 3'd0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/lcd_ram_byte_reader.sv
// Frame reader: walks the 64x1 RAM, builds character bytes and hands them out over valid/ready.
module lcd_ram_byte_reader
    import lcd_ram_pkg::*;
#(
    parameter int unsigned NumBytes = 8,
    parameter int unsigned BaseByte = 0,
    parameter bit          MsbFirst = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    lcd_ram_byte_reader_if.master bus,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_W-1:0] BaseAddr = byte_base_addr(BaseByte);
    localparam logic [2:0]        LastByte = 3'(NumBytes - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr, sample_en, full;

    lcd_bit_deserializer #(
        .MsbFirst (MsbFirst)
    ) u_deser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr),
        .sample_en_i (sample_en),
        .bit_i       (bus.ram_rdata),
        .data_o      (bus.byte_data),
        .full_o      (full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        clr        = 1'b0;
        sample_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRead;
                    addr_d     = BaseAddr;
                    byte_cnt_d = 3'd0;
                    busy_d     = 1'b1;
                    clr        = 1'b1;
                end
            end
            StRead: begin
                // ram_rdata reflects addr_q registered on the previous edge.
                sample_en = 1'b1;
                addr_d    = addr_q + ADDR_W'(1);
                if (full) begin
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (bus.byte_ready) begin
                    valid_d = 1'b0;
                    if (byte_cnt_q == LastByte) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            byte_cnt_q <= 3'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ram_addr   = addr_q;
    assign bus.byte_valid = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_lcd_ram_byte_reader.sv
// Scoreboard bench: three reader configurations share one behavioural 64x1 RAM.
module tb_lcd_ram_byte_reader;
    import lcd_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1, start2;
    logic        ready0, ready1, ready2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [63:0] ram;

    lcd_ram_byte_reader_if bus0 ();
    lcd_ram_byte_reader_if bus1 ();
    lcd_ram_byte_reader_if bus2 ();

    assign bus0.ram_rdata  = ram[bus0.ram_addr];
    assign bus1.ram_rdata  = ram[bus1.ram_addr];
    assign bus2.ram_rdata  = ram[bus2.ram_addr];
    assign bus0.byte_ready = ready0;
    assign bus1.byte_ready = ready1;
    assign bus2.byte_ready = ready2;

    lcd_ram_byte_reader u_dut0 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start0),
        .bus     (bus0),
        .busy_o  (busy0),
        .done_o  (done0)
    );

    lcd_ram_byte_reader #(
        .NumBytes (1),
        .BaseByte (0),
        .MsbFirst (1'b1)
    ) u_dut1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start1),
        .bus     (bus1),
        .busy_o  (busy1),
        .done_o  (done1)
    );

    lcd_ram_byte_reader #(
        .NumBytes (2),
        .BaseByte (7),
        .MsbFirst (1'b0)
    ) u_dut2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start2),
        .bus     (bus2),
        .busy_o  (busy2),
        .done_o  (done2)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
    int acc_cnt0 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame0();
        logic [63:0] img;
        img = 64'hFEDCBA9876543210;
        for (int i = 0; i < 8; i++) exp0.push_back(img[i*8 +: 8]);
    endtask

    task automatic wait_done0(input int max_cycles);
        for (int k = 0; k < max_cycles && !done0; k++) tick();
        check("dut0 done within budget", {31'd0, done0}, 32'd1);
    endtask

    // Monitor: a transfer is committed on the next rising edge whenever valid && ready.
    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        if (done2) done_cnt2++;
        if (bus0.byte_valid && bus0.byte_ready) begin
            acc_cnt0++;
            if (exp0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut0 byte: got %0h, none expected", bus0.byte_data);
            end else begin
                check("dut0 byte", {24'd0, bus0.byte_data}, {24'd0, exp0.pop_front()});
            end
        end
        if (bus1.byte_valid && bus1.byte_ready) begin
            if (exp1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1 byte: got %0h, none expected", bus1.byte_data);
            end else begin
                check("dut1 byte", {24'd0, bus1.byte_data}, {24'd0, exp1.pop_front()});
            end
        end
        if (bus2.byte_valid && bus2.byte_ready) begin
            if (exp2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut2 byte: got %0h, none expected", bus2.byte_data);
            end else begin
                check("dut2 byte", {24'd0, bus2.byte_data}, {24'd0, exp2.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_base;
        int done_base;
        ram    = 64'hFEDCBA9876543210;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        ready2 = 1'b0;
        repeat (2) tick();

        check("reset ram_addr", {26'd0, bus0.ram_addr}, 32'd0);
        check("reset byte_data", {24'd0, bus0.byte_data}, 32'd0);
        check("reset byte_valid", {31'd0, bus0.byte_valid}, 32'd0);
        check("reset busy", {31'd0, busy0}, 32'd0);
        check("reset done", {31'd0, done0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full default frame, MSB-first single byte, and wrapping two-byte frame in parallel.
        ready0 = 1'b1;
        ready1 = 1'b1;
        ready2 = 1'b1;
        push_frame0();
        exp1.push_back(8'h08);
        exp2.push_back(8'hFE);
        exp2.push_back(8'h10);
        start0 = 1'b1;
        start1 = 1'b1;
        start2 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        check("busy after start", {31'd0, busy0}, 32'd1);
        check("dut2 base address", {26'd0, bus2.ram_addr}, 32'd56);
        for (int c = 1; c <= 75; c++) begin
            tick();
            if (c <= 8) check("dut1 ram_addr walk", {26'd0, bus1.ram_addr}, c);
            if (c == 9) check("dut1 ram_addr held", {26'd0, bus1.ram_addr}, 32'd8);
            if (c == 7) begin
                check("valid not yet", {31'd0, bus0.byte_valid}, 32'd0);
                check("dut2 addr before wrap", {26'd0, bus2.ram_addr}, 32'd63);
            end
            if (c == 8) begin
                check("first valid latency", {31'd0, bus0.byte_valid}, 32'd1);
                check("dut2 addr wrapped", {26'd0, bus2.ram_addr}, 32'd0);
            end
            if (c == 71) check("busy before done", {31'd0, busy0}, 32'd1);
            if (c == 72) begin
                check("done at 72", {31'd0, done0}, 32'd1);
                check("busy low with done", {31'd0, busy0}, 32'd0);
            end
            if (c == 73) check("done one cycle", {31'd0, done0}, 32'd0);
        end
        check("dut0 queue drained", exp0.size(), 32'd0);
        check("dut1 queue drained", exp1.size(), 32'd0);
        check("dut2 queue drained", exp2.size(), 32'd0);
        check("dut0 done count", done_cnt0, 32'd1);
        check("dut1 done count", done_cnt1, 32'd1);
        check("dut2 done count", done_cnt2, 32'd1);

        // Back-pressure: hold the first byte for five cycles.
        ready0 = 1'b0;
        push_frame0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 20 && !bus0.byte_valid; k++) tick();
        check("stall valid seen", {31'd0, bus0.byte_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall data held", {24'd0, bus0.byte_data}, 32'h10);
            check("stall valid held", {31'd0, bus0.byte_valid}, 32'd1);
            check("stall addr frozen", {26'd0, bus0.ram_addr}, 32'd8);
            tick();
        end
        ready0 = 1'b1;
        tick();
        check("accept drops valid", {31'd0, bus0.byte_valid}, 32'd0);
        check("addr at accept", {26'd0, bus0.ram_addr}, 32'd8);
        tick();
        check("next byte reading", {26'd0, bus0.ram_addr}, 32'd9);
        wait_done0(150);
        tick();
        check("stall queue drained", exp0.size(), 32'd0);
        check("stall done count", done_cnt0, 32'd2);

        // START during READ is ignored; START with DONE is honoured.
        acc_base  = acc_cnt0;
        done_base = done_cnt0;
        push_frame0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(100);
        push_frame0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start with done honoured", {31'd0, busy0}, 32'd1);
        wait_done0(100);
        repeat (20) tick();
        check("bytes for two frames", acc_cnt0 - acc_base, 32'd16);
        check("dones for two frames", done_cnt0 - done_base, 32'd2);
        check("idle after frames", {31'd0, busy0}, 32'd0);
        check("restart queue drained", exp0.size(), 32'd0);

        // Reset in the middle of the third byte.
        done_base = done_cnt0;
        exp0.push_back(8'h10);
        exp0.push_back(8'h32);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (22) tick();
        rst_n = 1'b0;
        #2;
        check("mid reset ram_addr", {26'd0, bus0.ram_addr}, 32'd0);
        check("mid reset byte_data", {24'd0, bus0.byte_data}, 32'd0);
        check("mid reset byte_valid", {31'd0, bus0.byte_valid}, 32'd0);
        check("mid reset busy", {31'd0, busy0}, 32'd0);
        check("mid reset done", {31'd0, done0}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("no done on reset", done_cnt0 - done_base, 32'd0);
        check("two bytes before reset", exp0.size(), 32'd0);
        push_frame0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(100);
        tick();
        check("fresh frame drained", exp0.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
